disp_share_arbiter: RTL and testbench

- Shares the single 4-digit hex seven-segment display between up to NSRC debug sources. Typical sources are the pipeline CPU's PC, instruction word, ALU result and a register-file read port.
- Runs the scan sequencer: a digit tick divider and a position counter. It also runs a round-robin request/grant arbiter that switches owners only on display-frame boundaries.
- Outputs a digit position and nibble to the existing segment/digit decoder.

---
 rtl/disp_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_disp_share_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : disp_share_arbiter
// Brief   : Shares one 4-digit hex display between NSRC debug sources, with
//           frame-aligned round-robin ownership and the digit scan sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module disp_share_arbiter #(
  parameter int NSRC     = 4,
  parameter int SCAN_DIV = 10000,
  parameter int DWELL    = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      req,
  input  logic [16*NSRC-1:0]   src_data,
  output logic [NSRC-1:0]      grant,
  output logic [1:0]           pos,
  output logic [3:0]           nib,
  output logic                 blank,
  output logic                 frame_done
);

  localparam int c_TICK_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int c_IDX_W   = $clog2(NSRC);

  localparam logic [c_TICK_W-1:0]  c_TICK_MAX  = c_TICK_W'(SCAN_DIV - 1);
  localparam logic [c_DWELL_W-1:0] c_DWELL_MAX = c_DWELL_W'(DWELL - 1);
  localparam logic [c_IDX_W-1:0]   c_LAST_IDX  = c_IDX_W'(NSRC - 1);
  localparam logic [NSRC-1:0]      c_ONE       = {{(NSRC-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                 r_state;
  logic [c_TICK_W-1:0]    r_tick_cnt;
  logic [1:0]             r_pos;
  logic [NSRC-1:0]        r_grant;
  logic                   r_blank;
  logic                   r_frame_done;
  logic [15:0]            r_disp_val;
  logic [c_DWELL_W-1:0]   r_dwell_cnt;
  logic [c_IDX_W-1:0]     r_rr_last;

  logic                   w_tick;
  logic                   w_boundary;
  logic [NSRC-1:0]        w_cand;
  logic                   w_any;
  logic                   w_owner_req;
  logic                   w_leave;
  logic [c_IDX_W-1:0]     w_win;
  logic [15:0]            w_win_data;
  logic [15:0]            w_own_data;
  logic [3:0]             w_nib;

  assign w_tick      = (r_tick_cnt == c_TICK_MAX);
  assign w_boundary  = w_tick && (r_pos == 2'd3);
  // While holding, r_rr_last is the owner; exclude it so a switch goes elsewhere.
  assign w_cand      = (r_state == S_HOLD) ? (req & ~r_grant) : req;
  assign w_any       = |w_cand;
  assign w_owner_req = req[r_rr_last];
  assign w_leave     = (r_state == S_IDLE) || !w_owner_req ||
                       ((r_dwell_cnt == c_DWELL_MAX) && w_any);

  always_comb begin : p_rr_scan
    logic [c_IDX_W-1:0] w_idx;
    w_win = r_rr_last;
    w_idx = '0;
    // Descending scan so the nearest candidate after r_rr_last wins last.
    for (int j = NSRC; j >= 1; j--) begin
      w_idx = c_IDX_W'((int'(r_rr_last) + j) % NSRC);
      if (w_cand[w_idx]) w_win = w_idx;
    end
  end

  always_comb begin : p_data_mux
    w_win_data = '0;
    w_own_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_win == c_IDX_W'(i))     w_win_data = src_data[16*i +: 16];
      if (r_rr_last == c_IDX_W'(i)) w_own_data = src_data[16*i +: 16];
    end
  end

  always_comb begin : p_nib_sel
    case (r_pos)
      2'd0:    w_nib = r_disp_val[3:0];
      2'd1:    w_nib = r_disp_val[7:4];
      2'd2:    w_nib = r_disp_val[11:8];
      default: w_nib = r_disp_val[15:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_pos        <= 2'd0;
      r_grant      <= '0;
      r_blank      <= 1'b1;
      r_disp_val   <= 16'h0000;
      r_dwell_cnt  <= '0;
      r_rr_last    <= c_LAST_IDX;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) r_pos <= r_pos + 2'd1;

      if (w_boundary) begin
        if (w_leave && w_any) begin
          r_state     <= S_HOLD;
          r_grant     <= c_ONE << w_win;
          r_rr_last   <= w_win;
          r_dwell_cnt <= '0;
          r_blank     <= 1'b0;
          r_disp_val  <= w_win_data;
        end else if (w_leave) begin
          r_state     <= S_IDLE;
          r_grant     <= '0;
          r_dwell_cnt <= '0;
          r_blank     <= 1'b1;
          r_disp_val  <= 16'h0000;
        end else begin
          // Same owner: re-snapshot so the new frame shows its current value.
          r_blank    <= 1'b0;
          r_disp_val <= w_own_data;
          if (r_dwell_cnt != c_DWELL_MAX) r_dwell_cnt <= r_dwell_cnt + 1'b1;
        end
      end
    end
  end

  assign grant      = r_grant;
  assign pos        = r_pos;
  assign nib        = w_nib;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_disp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_disp_share_arbiter
// Brief   : Self-checking bench; per-frame expectations queued and compared
//           digit by digit as the display scans.
// Revision: 1.0 - initial release
// ============================================================================
module tb_disp_share_arbiter;

  localparam int NSRC     = 4;
  localparam int SCAN_DIV = 2;
  localparam int DWELL    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSRC-1:0]      req;
  logic [16*NSRC-1:0]   src_data;
  logic [NSRC-1:0]      grant;
  logic [1:0]           pos;
  logic [3:0]           nib;
  logic                 blank;
  logic                 frame_done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  grant;
    logic        blank;
    logic [15:0] val;
  } frame_t;

  frame_t sb[$];

  always #5 clk = ~clk;

  disp_share_arbiter #(
    .NSRC     (NSRC),
    .SCAN_DIV (SCAN_DIV),
    .DWELL    (DWELL)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .src_data   (src_data),
    .grant      (grant),
    .pos        (pos),
    .nib        (nib),
    .blank      (blank),
    .frame_done (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [15:0] v);
    src_data[16*i +: 16] = v;
  endtask

  function automatic void push_frame(input logic [3:0] g, input logic [15:0] v);
    frame_t e;
    e.grant = g;
    e.blank = (g == 4'b0000);
    e.val   = v;
    sb.push_back(e);
  endfunction

  task automatic sync_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    if (frame_done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_sync: frame_done=%b after 64 cycles, want 1", frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    src_data = '0;
    repeat (3) step();
    n_cmp++;
    if (grant !== 4'b0000 || blank !== 1'b1 || pos !== 2'd0 || nib !== 4'h0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: grant=%b blank=%b pos=%0d nib=%h fd=%b, want 0000 1 0 0 0",
               grant, blank, pos, nib, frame_done);
    end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_cmp++;
      if (pos !== 2'((k / 2) % 4) || frame_done !== (k % 8 == 0) || grant !== 4'b0000 || blank !== 1'b1) begin
        n_err++;
        $display("FAIL idle_scan k=%0d: pos=%0d fd=%b grant=%b blank=%b, want pos=%0d fd=%b grant=0000 blank=1",
                 k, pos, frame_done, grant, blank, (k / 2) % 4, (k % 8 == 0));
      end
    end
  endtask

  task automatic test_single_owner();
    frame_t e;
    set_src(0, 16'h1111);
    set_src(1, 16'h2222);
    set_src(2, 16'hBEEF);
    set_src(3, 16'h3333);
    req = 4'b0100;
    sync_frame();
    repeat (3) push_frame(4'b0100, 16'hBEEF);
    for (int f = 0; f < 3; f++) begin
      e = sb.pop_front();
      for (int d = 0; d < 4; d++) begin
        n_cmp++;
        if (grant !== e.grant || blank !== e.blank || pos !== 2'(d) || nib !== e.val[4*d +: 4]) begin
          n_err++;
          $display("FAIL single f%0d d%0d: grant=%b blank=%b pos=%0d nib=%h, want %b %b %0d %h",
                   f, d, grant, blank, pos, nib, e.grant, e.blank, d, e.val[4*d +: 4]);
        end
        step();
        step();
      end
    end
  endtask

  task automatic test_dwell_rotation();
    frame_t e;
    rst = 1'b1;
    req = 4'b0011;
    set_src(0, 16'h1111);
    set_src(1, 16'h2222);
    step();
    rst = 1'b0;
    sync_frame();
    push_frame(4'b0001, 16'h1111);
    push_frame(4'b0001, 16'h1111);
    push_frame(4'b0010, 16'h2222);
    push_frame(4'b0010, 16'h2222);
    push_frame(4'b0001, 16'h1111);
    for (int f = 0; f < 5; f++) begin
      e = sb.pop_front();
      for (int d = 0; d < 4; d++) begin
        n_cmp++;
        if (grant !== e.grant || blank !== e.blank || pos !== 2'(d) || nib !== e.val[4*d +: 4]) begin
          n_err++;
          $display("FAIL dwell f%0d d%0d: grant=%b blank=%b pos=%0d nib=%h, want %b %b %0d %h",
                   f, d, grant, blank, pos, nib, e.grant, e.blank, d, e.val[4*d +: 4]);
        end
        step();
        step();
      end
    end
  endtask

  task automatic test_release();
    frame_t e;
    rst = 1'b1;
    req = 4'b1001;
    set_src(0, 16'hAAAA);
    set_src(3, 16'hC0DE);
    step();
    rst = 1'b0;
    sync_frame();
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL release_setup: grant=%b, want 0001", grant);
    end
    repeat (3) step();
    req = 4'b1000;
    for (int s = 4; s < 8; s++) begin
      step();
      n_cmp++;
      if (grant !== 4'b0001) begin
        n_err++;
        $display("FAIL release_midframe s%0d: grant=%b, want 0001", s, grant);
      end
    end
    step();
    // Owner 3 must hold one extra frame only if its dwell count restarted.
    req = 4'b1001;
    push_frame(4'b1000, 16'hC0DE);
    push_frame(4'b1000, 16'hC0DE);
    push_frame(4'b0001, 16'hAAAA);
    for (int f = 0; f < 3; f++) begin
      e = sb.pop_front();
      for (int d = 0; d < 4; d++) begin
        n_cmp++;
        if (grant !== e.grant || blank !== e.blank || pos !== 2'(d) || nib !== e.val[4*d +: 4]) begin
          n_err++;
          $display("FAIL release f%0d d%0d: grant=%b blank=%b pos=%0d nib=%h, want %b %b %0d %h",
                   f, d, grant, blank, pos, nib, e.grant, e.blank, d, e.val[4*d +: 4]);
        end
        step();
        step();
      end
    end
  endtask

  task automatic test_src_change();
    frame_t e;
    rst = 1'b1;
    req = 4'b0010;
    set_src(1, 16'h1234);
    step();
    rst = 1'b0;
    sync_frame();
    push_frame(4'b0010, 16'h1234);
    push_frame(4'b0010, 16'h5678);
    for (int f = 0; f < 2; f++) begin
      e = sb.pop_front();
      for (int d = 0; d < 4; d++) begin
        n_cmp++;
        if (grant !== e.grant || blank !== e.blank || pos !== 2'(d) || nib !== e.val[4*d +: 4]) begin
          n_err++;
          $display("FAIL src_change f%0d d%0d: grant=%b blank=%b pos=%0d nib=%h, want %b %b %0d %h",
                   f, d, grant, blank, pos, nib, e.grant, e.blank, d, e.val[4*d +: 4]);
        end
        step();
        if (f == 0 && d == 1) set_src(1, 16'h5678);
        step();
      end
    end
  endtask

  task automatic test_reset_midframe();
    frame_t e;
    set_src(2, 16'h9ABC);
    repeat (4) step();
    n_cmp++;
    if (pos !== 2'd2 || grant !== 4'b0010) begin
      n_err++;
      $display("FAIL midreset_setup: pos=%0d grant=%b, want 2 0010", pos, grant);
    end
    rst = 1'b1;
    req = 4'b0110;
    step();
    n_cmp++;
    if (grant !== 4'b0000 || pos !== 2'd0 || blank !== 1'b1 || nib !== 4'h0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_state: grant=%b pos=%0d blank=%b nib=%h fd=%b, want 0000 0 1 0 0",
               grant, pos, blank, nib, frame_done);
    end
    rst = 1'b0;
    sync_frame();
    push_frame(4'b0010, 16'h5678);
    e = sb.pop_front();
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (grant !== e.grant || blank !== e.blank || pos !== 2'(d) || nib !== e.val[4*d +: 4]) begin
        n_err++;
        $display("FAIL midreset_regrant d%0d: grant=%b blank=%b pos=%0d nib=%h, want %b %b %0d %h",
                 d, grant, blank, pos, nib, e.grant, e.blank, d, e.val[4*d +: 4]);
      end
      step();
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_dwell_rotation();
    test_release();
    test_src_change();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
